// File: rtl/ddram_responder.sv
// ddram_responder: on-chip 64-bit backing store that answers MiSTer DDRAM read/write bursts.
// Define DDRAM_RESP_STALL_EN to add LFSR-driven BUSY stalls while idle or mid write burst.
module ddram_responder #(
  parameter int unsigned ADDR_BITS    = 12,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  input  logic        DDRAM_RD,
  input  logic        DDRAM_WE,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_DATA} state_e;
  typedef logic [ADDR_BITS-1:0] addr_t;

  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  addr_t       addr_q, addr_d;
  logic [7:0]  beats_q, beats_d;
  logic [3:0]  lat_q, lat_d;
  logic        busy_q, busy_d;
  logic [63:0] dout_q, dout_d;
  logic        ready_q, ready_d;

  logic [63:0] mem [2**ADDR_BITS];
  logic [63:0] rd_word_q;

  logic        stall, accept, wr_en, beat;
  addr_t       wr_addr, rd_addr, req_addr;
  logic [7:0]  req_left;
  logic        addr_hi_unused;

  assign req_addr       = DDRAM_ADDR[ADDR_BITS-1:0];
  assign addr_hi_unused = ^DDRAM_ADDR[28:ADDR_BITS];
  // A zero burst count behaves as a single beat, so beats remaining after the first is 0.
  assign req_left       = (DDRAM_BURSTCNT == 8'd0) ? 8'd0 : DDRAM_BURSTCNT - 8'd1;

`ifdef DDRAM_RESP_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = (lfsr_q[1:0] == 2'b00) && ((state_q == IDLE) || (state_q == WR_BURST));
`else
  logic [15:0] seed_unused;
  assign seed_unused = LFSR_SEED;
  assign stall       = 1'b0;
`endif

  assign DDRAM_BUSY       = busy_q | stall;
  assign DDRAM_DOUT       = dout_q;
  assign DDRAM_DOUT_READY = ready_q;
  assign accept           = (DDRAM_RD | DDRAM_WE) & ~DDRAM_BUSY;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    lat_d   = lat_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    wr_en   = 1'b0;
    wr_addr = addr_q;
    beat    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (accept && DDRAM_WE) begin
          wr_en   = 1'b1;
          wr_addr = req_addr;
          addr_d  = req_addr + addr_t'(1);
          beats_d = req_left;
          if (req_left != 8'd0) state_d = WR_BURST;
        end else if (accept) begin
          addr_d  = req_addr;
          beats_d = req_left;
          lat_d   = LAT_INIT;
          busy_d  = 1'b1;
          state_d = RD_WAIT;
        end
      end
      WR_BURST: begin
        if (accept && DDRAM_WE) begin
          wr_en   = 1'b1;
          addr_d  = addr_q + addr_t'(1);
          beats_d = beats_q - 8'd1;
          if (beats_q == 8'd1) state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (lat_q == 4'd0) begin
          beat    = 1'b1;
          state_d = RD_DATA;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RD_DATA: begin
        if (beats_q != 8'd0) begin
          beat    = 1'b1;
          beats_d = beats_q - 8'd1;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (beat) begin
      ready_d = 1'b1;
      dout_d  = rd_word_q;
      addr_d  = addr_q + addr_t'(1);
    end
  end

  // Prefetch runs one word ahead: on a beat edge it fetches the word for the following beat.
  assign rd_addr = (state_q == IDLE) ? req_addr : addr_q + addr_t'(beat);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b1;
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
    end
  end

  // NOTE: the backing store and its read register take no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (DDRAM_BE[i]) mem[wr_addr][8*i +: 8] <= DDRAM_DIN[8*i +: 8];
      end
    end
    rd_word_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_ddram_responder.sv
// tb_ddram_responder: directed self-checking bench for ddram_responder (defaults ADDR_BITS=12, READ_LATENCY=2).
module tb_ddram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busy;
  logic [7:0]  burstcnt = '0;
  logic [28:0] addr = '0;
  logic        rd = 1'b0;
  logic        we = 1'b0;
  logic [63:0] din = '0;
  logic [7:0]  be = '0;
  logic [63:0] dout;
  logic        dout_ready;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_data [8];

  ddram_responder dut (
    .clk              (clk),
    .reset            (reset),
    .DDRAM_BUSY       (busy),
    .DDRAM_BURSTCNT   (burstcnt),
    .DDRAM_ADDR       (addr),
    .DDRAM_RD         (rd),
    .DDRAM_WE         (we),
    .DDRAM_DIN        (din),
    .DDRAM_BE         (be),
    .DDRAM_DOUT       (dout),
    .DDRAM_DOUT_READY (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the currently driven RD/WE until an edge with BUSY low accepts it.
  task automatic issue(input string tag);
    logic acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = !busy;
      tick();
    end
    check({tag, "_accept"}, 64'(acc), 64'd1);
    rd = 1'b0;
    we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [28:0] a, input logic [63:0] d,
                    input logic [7:0] b, input logic [7:0] cnt);
    addr = a; din = d; be = b; burstcnt = cnt; we = 1'b1;
    issue(tag);
  endtask

  task automatic rd_check(input string tag, input logic [28:0] a, input logic [7:0] cnt);
    int n = 0;
    int beats = (cnt == 8'd0) ? 1 : int'(cnt);
    addr = a; burstcnt = cnt; rd = 1'b1;
    issue(tag);
    check({tag, "_busy_wait"}, 64'(busy), 64'd1);
    while (!dout_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd2);
    for (int k = 0; k < beats; k++) begin
      check($sformatf("%s_data%0d", tag, k), dout, exp_data[k]);
      check($sformatf("%s_rdy%0d", tag, k), 64'(dout_ready), 64'd1);
      check($sformatf("%s_busy%0d", tag, k), 64'(busy), 64'd1);
      tick();
    end
    check({tag, "_rdy_end"}, 64'(dout_ready), 64'd0);
    check({tag, "_dout_hold"}, dout, exp_data[beats-1]);
`ifndef DDRAM_RESP_STALL_EN
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
`endif
  endtask

  initial begin
    int   n;
    logic seen;

    // Reset values, then release.
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_rdy", 64'(dout_ready), 64'd0);
    check("rst_dout", dout, 64'd0);
    reset = 1'b1;
    check("rel_busy_hi", 64'(busy), 64'd1);
    tick();
`ifndef DDRAM_RESP_STALL_EN
    check("rel_busy_lo", 64'(busy), 64'd0);
`endif

    // Single write then read-after-write.
    wr("w5", 29'd5, 64'h0123_4567_89AB_CDEF, 8'hFF, 8'd1);
    exp_data[0] = 64'h0123_4567_89AB_CDEF;
    rd_check("r5", 29'd5, 8'd1);

    // Four-beat burst with a stray RD during WR_BURST that must be ignored.
    wr("wb0", 29'd100, 64'd1, 8'hFF, 8'd4);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    repeat (3) tick();
    check("wb_rd_ignored", 64'(dout_ready), 64'd0);
    wr("wb1", 29'd0, 64'd2, 8'hFF, 8'd0);
    wr("wb2", 29'd0, 64'd3, 8'hFF, 8'd0);
    wr("wb3", 29'd0, 64'd4, 8'hFF, 8'd0);
    for (int k = 0; k < 4; k++) exp_data[k] = 64'(k + 1);
    rd_check("rb", 29'd100, 8'd4);

    // Byte enables: only the low four lanes are cleared.
    wr("be_ones", 29'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'd1);
    wr("be_low", 29'd7, 64'd0, 8'h0F, 8'd1);
    exp_data[0] = 64'hFFFF_FFFF_0000_0000;
    rd_check("rbe", 29'd7, 8'd1);

    // Burst wrap at the top of the store and upper-address aliasing.
    wr("wrap0", 29'd4095, 64'hAAAA_0000_AAAA_0001, 8'hFF, 8'd2);
    wr("wrap1", 29'd0, 64'hBBBB_0000_BBBB_0002, 8'hFF, 8'd0);
    exp_data[0] = 64'hAAAA_0000_AAAA_0001;
    rd_check("r4095", 29'd4095, 8'd1);
    exp_data[0] = 64'hBBBB_0000_BBBB_0002;
    rd_check("r0", 29'd0, 8'd1);
    rd_check("r4096", 29'd4096, 8'd1);
    exp_data[0] = 64'hAAAA_0000_AAAA_0001;
    exp_data[1] = 64'hBBBB_0000_BBBB_0002;
    rd_check("rwrap", 29'd4095, 8'd2);

    // BURSTCNT=0 is one beat on both write and read.
    wr("wz", 29'd50, 64'h5050, 8'hFF, 8'd0);
    wr("wz_next", 29'd51, 64'h5151, 8'hFF, 8'd1);
    exp_data[0] = 64'h5050;
    rd_check("rz", 29'd50, 8'd0);
    exp_data[0] = 64'h5151;
    rd_check("rz_next", 29'd51, 8'd1);

    // RD and WE together: write wins, read is dropped.
    addr = 29'd3; din = 64'd9; be = 8'hFF; burstcnt = 8'd1; we = 1'b1; rd = 1'b1;
    issue("coll");
    seen = 1'b0;
    repeat (8) begin
      seen |= dout_ready;
      tick();
    end
    check("coll_no_rdy", 64'(seen), 64'd0);
    exp_data[0] = 64'd9;
    rd_check("coll_rd", 29'd3, 8'd1);

    // Reset asserted during beat 2 of an eight-beat read.
    wr("mw0", 29'd200, 64'd200, 8'hFF, 8'd8);
    for (int k = 1; k < 8; k++) wr("mwk", 29'd0, 64'(200 + k), 8'hFF, 8'd0);
    addr = 29'd200; burstcnt = 8'd8; rd = 1'b1;
    issue("mrst");
    n = 0;
    while (!dout_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("mrst_beat2", dout, 64'd202);
    #2 reset = 1'b0;
    #1;
    check("mrst_rdy", 64'(dout_ready), 64'd0);
    check("mrst_busy", 64'(busy), 64'd1);
    check("mrst_dout", dout, 64'd0);
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen |= dout_ready;
    end
    check("mrst_quiet", 64'(seen), 64'd0);
    reset = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) exp_data[k] = 64'(200 + k);
    rd_check("mrst_re", 29'd200, 8'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
